// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM:
// state encoding, opcode constants, ALUop classes and the control-word bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    // Every datapath control produced by the FSM, bundled so the whole word
    // can be cleared in one assignment.
    typedef struct packed {
        logic [2:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
    } ctrl_t;

    // True for the immediate-arithmetic opcodes executed in S_I_EXEC.
    function automatic logic is_i_type(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_i_type_aluop_decode.sv
// Combinational opcode -> ALUop map for the immediate-arithmetic instructions.
module i_type_aluop_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] alu_op
);

    // Select the ALU class for addi/andi/ori/slti; anything else adds.
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_ADDI: alu_op = ALU_ADD;
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Sequences
// fetch/decode/execute/memory/writeback from the opcode and stalls on
// mem_ready. Optional macro CTRL_PERF_CNT_EN adds instruction and cycle
// counters (instr_count, cycle_count, CNT_W bits each).
module mips_multicycle_control
    import mips_ctrl_pkg::*;
`ifdef CTRL_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [2:0] ALUop,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       illegal_op
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
`endif
);

    state_t     state_reg;
    state_t     state_next;
    logic       illegal_reg;
    logic       illegal_next;
    ctrl_t      ctrl_next;
    ctrl_t      ctrl_out;
    logic [2:0] i_alu_op;

    i_type_aluop_decode u_i_type_aluop_decode (
        .opcode (opcode),
        .alu_op (i_alu_op)
    );

    // State and sticky illegal-opcode flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    // Next-state selection and Moore control decode (mem_ready qualifies
    // the fetch strobes and the exits of the memory states).
    always_comb begin
        ctrl_next    = '0;
        state_next   = state_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            S_FETCH: begin
                ctrl_next.mem_read  = 1'b1;
                ctrl_next.alu_src_b = 2'b01;
                ctrl_next.alu_op    = ALU_ADD;
                ctrl_next.ir_write  = mem_ready;
                ctrl_next.pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl_next.alu_src_b = 2'b11;
                ctrl_next.alu_op    = ALU_ADD;
                if (opcode == OP_RTYPE) begin
                    state_next = S_R_EXEC;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_MEM_ADDR;
                end else if (opcode == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_next = S_JUMP;
                end else if (is_i_type(opcode)) begin
                    state_next = S_I_EXEC;
                end else begin
                    state_next   = S_FETCH;
                    illegal_next = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_src_b = 2'b10;
                ctrl_next.alu_op    = ALU_ADD;
                state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl_next.mem_read = 1'b1;
                ctrl_next.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                ctrl_next.reg_write  = 1'b1;
                ctrl_next.mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl_next.mem_write = 1'b1;
                ctrl_next.i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_src_b = 2'b00;
                ctrl_next.alu_op    = ALU_RTYPE;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                ctrl_next.reg_write = 1'b1;
                ctrl_next.reg_dst   = 1'b1;
                state_next = S_FETCH;
            end
            S_I_EXEC: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_src_b = 2'b10;
                ctrl_next.alu_op    = i_alu_op;
                state_next = S_I_WB;
            end
            S_I_WB: begin
                ctrl_next.reg_write = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_next.alu_src_a     = 1'b1;
                ctrl_next.alu_src_b     = 2'b00;
                ctrl_next.alu_op        = ALU_SUB;
                ctrl_next.pc_write_cond = 1'b1;
                ctrl_next.pc_source     = 2'b01;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                ctrl_next.pc_write  = 1'b1;
                ctrl_next.pc_source = 2'b10;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Hold every control low while reset is asserted so an aborted
    // instruction cannot strobe a write in the reset cycle.
    always_comb begin
        ctrl_out = reset ? '0 : ctrl_next;
    end

    assign ALUop         = ctrl_out.alu_op;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_source     = ctrl_out.pc_source;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign illegal_op    = illegal_reg & ~reset;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] instr_count_reg;
    logic [CNT_W-1:0] cycle_count_reg;

    // Free-running performance counters; an instruction is counted when
    // its fetch completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_reg <= '0;
            cycle_count_reg <= '0;
        end else begin
            cycle_count_reg <= cycle_count_reg + CNT_W'(1);
            if (state_reg == S_FETCH && mem_ready) begin
                instr_count_reg <= instr_count_reg + CNT_W'(1);
            end
        end
    end

    assign instr_count = reset ? '0 : instr_count_reg;
    assign cycle_count = reset ? '0 : cycle_count_reg;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench for mips_multicycle_control. A reference
// model expands each fetched opcode into its list of remaining phases and
// predicts the control word for every cycle.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [2:0] ALUop;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_src_b;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count, cycle_count;
`endif

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .ALUop         (ALUop),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .illegal_op    (illegal_op)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instr_count   (instr_count),
        .cycle_count   (cycle_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Phases an instruction walks through after its fetch.
    localparam int PH_DEC = 1, PH_MADDR = 2, PH_MRD = 3, PH_MWB = 4, PH_MWR = 5;
    localparam int PH_REX = 6, PH_RWB = 7, PH_IEX = 8, PH_IWB = 9, PH_BR = 10, PH_J = 11;
    localparam int PH_FETCH = 0;

    // Control word: {ALUop, pc_write, pc_write_cond, pc_source, i_or_d,
    // mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    // alu_src_a, alu_src_b}
    function automatic logic [16:0] exp_ctrl(input int ph, input logic [5:0] op, input logic mr);
        logic [2:0] aop; logic pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, sa;
        logic [1:0] ps, sb;
        {aop, pw, pwc, ps, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb} = '0;
        case (ph)
            PH_FETCH: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            PH_DEC:   begin sb = 2'b11; end
            PH_MADDR: begin sa = 1; sb = 2'b10; end
            PH_MRD:   begin mrd = 1; iod = 1; end
            PH_MWB:   begin rw = 1; m2r = 1; end
            PH_MWR:   begin mwr = 1; iod = 1; end
            PH_REX:   begin sa = 1; aop = 3'b111; end
            PH_RWB:   begin rw = 1; rd = 1; end
            PH_IEX: begin
                sa = 1; sb = 2'b10;
                if (op == 6'b001100) aop = 3'b100;
                else if (op == 6'b001101) aop = 3'b001;
                else if (op == 6'b001010) aop = 3'b101;
                else aop = 3'b000;
            end
            PH_IWB:   begin rw = 1; end
            PH_BR:    begin sa = 1; aop = 3'b110; pwc = 1; ps = 2'b01; end
            PH_J:     begin pw = 1; ps = 2'b10; end
            default:  ;
        endcase
        return {aop, pw, pwc, ps, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                          6'b001000, 6'b001100, 6'b001101, 6'b001010};
    endfunction

    int          ph_q[$];
    bit          model_illegal;
    logic [31:0] model_cyc, model_ins;
    logic [5:0]  pending_op;
    logic [5:0]  directed_ops [10] = '{6'b000000, 6'b100011, 6'b000100, 6'b001101, 6'b111111,
                                       6'b101011, 6'b000010, 6'b001000, 6'b001100, 6'b001010};
    logic [5:0]  legal_ops [9]     = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                       6'b001000, 6'b001100, 6'b001101, 6'b001010};
    int          n_fetched;

    // Queue the phases that follow a completed fetch of op.
    task automatic load_instr(input logic [5:0] op);
        ph_q.delete();
        ph_q.push_back(PH_DEC);
        case (op)
            6'b000000: begin ph_q.push_back(PH_REX); ph_q.push_back(PH_RWB); end
            6'b100011: begin ph_q.push_back(PH_MADDR); ph_q.push_back(PH_MRD); ph_q.push_back(PH_MWB); end
            6'b101011: begin ph_q.push_back(PH_MADDR); ph_q.push_back(PH_MWR); end
            6'b000100: ph_q.push_back(PH_BR);
            6'b000010: ph_q.push_back(PH_J);
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                ph_q.push_back(PH_IEX); ph_q.push_back(PH_IWB);
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [16:0] got_ctrl, want;
        int          ph;
        reset         = 1'b1;
        mem_ready     = 1'b1;
        opcode        = 6'd0;
        pending_op    = 6'd0;
        model_illegal = 1'b0;
        model_cyc     = 0;
        model_ins     = 0;
        n_fetched     = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            opcode = pending_op;
            if (cyc < 2) reset = 1'b1;
            else if (cyc < 150) reset = 1'b0;
            else reset = ($urandom_range(0, 99) == 0);
            mem_ready = (cyc < 4) ? 1'b1 : ($urandom_range(0, 9) < 7);
            #4;

            ph = (ph_q.size() == 0) ? PH_FETCH : ph_q[0];
            want = reset ? 17'd0 : exp_ctrl(ph, opcode, mem_ready);
            got_ctrl = {ALUop, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                        ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b};
            check_eq($sformatf("ctrl cyc=%0d ph=%0d op=%06b rst=%0d mr=%0d", cyc, ph, opcode, reset, mem_ready),
                     32'(got_ctrl), 32'(want));
            check_eq($sformatf("illegal_op cyc=%0d", cyc), 32'(illegal_op),
                     32'(reset ? 1'b0 : model_illegal));
`ifdef CTRL_PERF_CNT_EN
            check_eq($sformatf("cycle_count cyc=%0d", cyc), cycle_count, reset ? 32'd0 : model_cyc);
            check_eq($sformatf("instr_count cyc=%0d", cyc), instr_count, reset ? 32'd0 : model_ins);
`endif

            // Advance the model across the coming clock edge.
            if (reset) begin
                ph_q.delete();
                model_illegal = 1'b0;
                model_cyc = 0;
                model_ins = 0;
            end else begin
                model_cyc++;
                if (ph == PH_FETCH) begin
                    if (mem_ready) begin
                        model_ins++;
                        if (n_fetched < 10) pending_op = directed_ops[n_fetched];
                        else if ($urandom_range(0, 4) == 0) pending_op = 6'($urandom);
                        else pending_op = legal_ops[$urandom_range(0, 8)];
                        n_fetched++;
                        load_instr(pending_op);
                    end
                end else begin
                    if (ph == PH_DEC && !is_legal(opcode)) model_illegal = 1'b1;
                    if (!((ph == PH_MRD || ph == PH_MWR) && !mem_ready)) void'(ph_q.pop_front());
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
